// File: rtl/instr_fetch_responder_pkg.sv
// Shared types and constants for the instruction-fetch responder slice.
package instr_fetch_responder_pkg;

   // Responder FSM states: idle, counting down the fetch latency, holding a response
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } fetch_state_t;

   // Word returned for misaligned or out-of-range fetches
   localparam logic [31:0] ERR_DATA = 32'h0000_0000;

   // Countdown holds LATENCY-1 at most, so it never needs more than clog2(LATENCY) bits
   function automatic int countdown_width(input int latency);
      return (latency <= 2) ? 1 : $clog2(latency);
   endfunction

endpackage

// File: rtl/instr_fetch_responder_if.sv
// Fetch request/response handshake between the program counter/decode side and the responder.
interface instr_fetch_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;

   // PC/decode side: issues requests and consumes responses
   modport master (
      output req_valid,
      output req_addr,
      output rsp_ready,
      input  req_ready,
      input  rsp_valid,
      input  rsp_data,
      input  rsp_err
   );

   // Responder side: accepts requests and produces responses
   modport slave (
      input  req_valid,
      input  req_addr,
      input  rsp_ready,
      output req_ready,
      output rsp_valid,
      output rsp_data,
      output rsp_err
   );
endinterface

// File: rtl/instr_fetch_responder_mem_array.sv
// Instruction storage: one synchronous write port, one combinational read port.
// The read is sampled by the responder on a clock edge, so a write on that same
// edge is not yet visible and the old word is returned (read-before-write).
module instr_mem_array #(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_idx,
   input  logic [31:0]   wr_data,
   input  logic [AW-1:0] rd_idx,
   output logic [31:0]   rd_data
);

   logic [31:0] mem [DEPTH_WORDS];

   // Load port write; contents are intentionally not reset so boot images survive a reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/instr_fetch_responder.sv
// Responder end of the instruction-fetch interface: accepts one byte-address
// request at a time, returns the instruction word after LATENCY cycles, and
// counts completed responses. Memory is filled through the load port.
module instr_fetch_responder
   import instr_fetch_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   instr_fetch_responder_if.slave         bus,
   input  logic                           flush,
   input  logic                           ld_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
   input  logic [31:0]                    ld_data,
   output logic [31:0]                    fetch_count
);

   localparam int            AW       = $clog2(DEPTH_WORDS);
   localparam int            CW       = countdown_width(LATENCY);
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

   fetch_state_t  state;
   logic [CW-1:0] cnt;
   logic [31:0]   addr_q;
   logic          rsp_valid_q;
   logic [31:0]   rsp_data_q;
   logic          rsp_err_q;
   logic [31:0]   count_q;

   logic [AW-1:0] rd_idx;
   logic [31:0]   rd_data;
   logic          handshake;
   logic          accept;
   logic          new_bad;
   logic          held_bad;

   // Misaligned addresses and addresses past the end of memory produce an error response
   function automatic logic addr_bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH_WORDS));
   endfunction

   assign new_bad   = addr_bad(bus.req_addr);
   assign held_bad  = addr_bad(addr_q);
   assign handshake = (state == RESP) && bus.rsp_ready;
   assign accept    = !flush && bus.req_valid && ((state == IDLE) || handshake);

   // With LATENCY=1 the word is read on the accepting edge straight from the request address
   assign rd_idx = (state == WAIT) ? addr_q[AW+1:2] : bus.req_addr[AW+1:2];

   assign bus.req_ready = !reset && !flush && ((state == IDLE) || handshake);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign fetch_count   = count_q;

   instr_mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (ld_en),
      .wr_idx  (ld_addr),
      .wr_data (ld_data),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

   // Fetch FSM: flush beats everything, then request acceptance, then latency countdown and response hold
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         addr_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         count_q     <= '0;
      end else if (flush) begin
         state       <= IDLE;
         rsp_valid_q <= 1'b0;
      end else begin
         if (handshake) begin
            count_q <= count_q + 32'd1;
         end
         if (accept) begin
            addr_q <= bus.req_addr;
            if (LATENCY == 1) begin
               state       <= RESP;
               rsp_valid_q <= 1'b1;
               rsp_data_q  <= new_bad ? ERR_DATA : rd_data;
               rsp_err_q   <= new_bad;
            end else begin
               state       <= WAIT;
               rsp_valid_q <= 1'b0;
               cnt         <= CNT_LOAD;
            end
         end else begin
            case (state)
               WAIT: begin
                  if (cnt == '0) begin
                     state       <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_data_q  <= held_bad ? ERR_DATA : rd_data;
                     rsp_err_q   <= held_bad;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               RESP: begin
                  if (bus.rsp_ready) begin
                     state       <= IDLE;
                     rsp_valid_q <= 1'b0;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed bench for instr_fetch_responder: one LATENCY=2 instance for the
// main fetch/error/back-pressure/flush/reset scenarios and one LATENCY=1
// instance for back-to-back throughput and read-before-write.
module tb_instr_fetch_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush_a, flush_b;
   logic        ld_en_a, ld_en_b;
   logic [7:0]  ld_addr_a, ld_addr_b;
   logic [31:0] ld_data_a, ld_data_b;
   logic [31:0] fetch_count_a, fetch_count_b;

   int compare_count  = 0;
   int mismatch_count = 0;

   instr_fetch_responder_if bus_a ();
   instr_fetch_responder_if bus_b ();

   // 100 MHz free-running clock
   always #5 clk = ~clk;

   instr_fetch_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_a (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus_a),
      .flush       (flush_a),
      .ld_en       (ld_en_a),
      .ld_addr     (ld_addr_a),
      .ld_data     (ld_data_a),
      .fetch_count (fetch_count_a)
   );

   instr_fetch_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_b (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus_b),
      .flush       (flush_b),
      .ld_en       (ld_en_b),
      .ld_addr     (ld_addr_b),
      .ld_data     (ld_data_b),
      .fetch_count (fetch_count_b)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compare_count++;
      if (observed !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_a(input logic [7:0] idx, input logic [31:0] data);
      ld_en_a   = 1'b1;
      ld_addr_a = idx;
      ld_data_a = data;
      step();
      ld_en_a   = 1'b0;
   endtask

   task automatic load_b(input logic [7:0] idx, input logic [31:0] data);
      ld_en_b   = 1'b1;
      ld_addr_b = idx;
      ld_data_b = data;
      step();
      ld_en_b   = 1'b0;
   endtask

   // Single fetch on instance A with rsp_ready held high; checks latency, payload and count
   task automatic fetch_a(input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_err,
                          input logic [31:0] exp_count, input string tag);
      int cycles;
      bus_a.rsp_ready = 1'b1;
      bus_a.req_valid = 1'b1;
      bus_a.req_addr  = addr;
      #1;
      checkOutput({tag, "_req_ready"}, bus_a.req_ready, 1);
      step();
      bus_a.req_valid = 1'b0;
      cycles = 0;
      while (!bus_a.rsp_valid && cycles < 10) begin
         step();
         cycles++;
      end
      checkOutput({tag, "_latency"}, cycles, 2);
      checkOutput({tag, "_data"}, bus_a.rsp_data, exp_data);
      checkOutput({tag, "_err"}, bus_a.rsp_err, exp_err);
      step();
      checkOutput({tag, "_count"}, fetch_count_a, exp_count);
      checkOutput({tag, "_valid_drop"}, bus_a.rsp_valid, 0);
   endtask

   // Stimulus sequence
   initial begin
      reset = 1'b1;
      flush_a = 1'b0; flush_b = 1'b0;
      ld_en_a = 1'b0; ld_en_b = 1'b0;
      ld_addr_a = '0; ld_addr_b = '0;
      ld_data_a = '0; ld_data_b = '0;
      bus_a.req_valid = 1'b0; bus_a.req_addr = '0; bus_a.rsp_ready = 1'b0;
      bus_b.req_valid = 1'b0; bus_b.req_addr = '0; bus_b.rsp_ready = 1'b0;

      step();
      checkOutput("reset_req_ready", bus_a.req_ready, 0);
      checkOutput("reset_rsp_valid", bus_a.rsp_valid, 0);
      checkOutput("reset_rsp_data", bus_a.rsp_data, 0);
      checkOutput("reset_rsp_err", bus_a.rsp_err, 0);
      checkOutput("reset_count", fetch_count_a, 0);
      step();
      reset = 1'b0;

      load_a(8'd3, 32'h1234_5678);
      load_a(8'd5, 32'hCAFE_F00D);
      load_a(8'd2, 32'hA5A5_0002);

      fetch_a(32'h0000_000C, 32'h1234_5678, 1'b0, 1, "basic");
      fetch_a(32'h0000_000E, 32'h0000_0000, 1'b1, 2, "bad_align");
      fetch_a(32'h0000_0400, 32'h0000_0000, 1'b1, 3, "bad_range");

      // Back-pressure with a second request waiting behind the held response
      bus_a.rsp_ready = 1'b0;
      bus_a.req_valid = 1'b1;
      bus_a.req_addr  = 32'h0000_0014;
      step();
      bus_a.req_addr  = 32'h0000_0008;
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_valid", bus_a.rsp_valid, 1);
         checkOutput("bp_data", bus_a.rsp_data, 32'hCAFE_F00D);
         checkOutput("bp_req_ready", bus_a.req_ready, 0);
         checkOutput("bp_count", fetch_count_a, 3);
         step();
      end
      bus_a.rsp_ready = 1'b1;
      #1;
      checkOutput("bp_release_req_ready", bus_a.req_ready, 1);
      step();
      bus_a.req_valid = 1'b0;
      checkOutput("bp_release_count", fetch_count_a, 4);
      checkOutput("bp_release_valid", bus_a.rsp_valid, 0);
      step();
      checkOutput("bp_next_wait", bus_a.rsp_valid, 0);
      step();
      checkOutput("bp_next_valid", bus_a.rsp_valid, 1);
      checkOutput("bp_next_data", bus_a.rsp_data, 32'hA5A5_0002);
      step();
      checkOutput("bp_next_count", fetch_count_a, 5);

      // Flush while counting down
      bus_a.req_valid = 1'b1;
      bus_a.req_addr  = 32'h0000_000C;
      step();
      bus_a.req_valid = 1'b0;
      flush_a = 1'b1;
      #1;
      checkOutput("flush_wait_req_ready", bus_a.req_ready, 0);
      step();
      flush_a = 1'b0;
      #1;
      checkOutput("flush_wait_idle_ready", bus_a.req_ready, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("flush_wait_no_rsp", bus_a.rsp_valid, 0);
      end
      checkOutput("flush_wait_count", fetch_count_a, 5);

      // Flush while holding a response, with rsp_ready high in the flush cycle
      bus_a.rsp_ready = 1'b0;
      bus_a.req_valid = 1'b1;
      bus_a.req_addr  = 32'h0000_000C;
      step();
      bus_a.req_valid = 1'b0;
      step();
      step();
      checkOutput("flush_resp_pre_valid", bus_a.rsp_valid, 1);
      flush_a = 1'b1;
      bus_a.rsp_ready = 1'b1;
      step();
      flush_a = 1'b0;
      bus_a.rsp_ready = 1'b0;
      #1;
      checkOutput("flush_resp_valid", bus_a.rsp_valid, 0);
      checkOutput("flush_resp_count", fetch_count_a, 5);
      checkOutput("flush_resp_idle_ready", bus_a.req_ready, 1);
      step();
      checkOutput("flush_resp_no_rsp", bus_a.rsp_valid, 0);

      // Reset while counting down
      bus_a.rsp_ready = 1'b1;
      bus_a.req_valid = 1'b1;
      bus_a.req_addr  = 32'h0000_000C;
      step();
      bus_a.req_valid = 1'b0;
      reset = 1'b1;
      #1;
      checkOutput("rst_mid_valid", bus_a.rsp_valid, 0);
      checkOutput("rst_mid_count", fetch_count_a, 0);
      checkOutput("rst_mid_req_ready", bus_a.req_ready, 0);
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checkOutput("rst_mid_no_rsp", bus_a.rsp_valid, 0);
      end
      fetch_a(32'h0000_000C, 32'h1234_5678, 1'b0, 1, "post_rst");

      // LATENCY=1: back-to-back fetches with a load to word 1 on its sampling edge
      load_b(8'd0, 32'h1111_0000);
      load_b(8'd1, 32'h2222_0001);
      load_b(8'd2, 32'h3333_0002);
      bus_b.rsp_ready = 1'b1;
      bus_b.req_valid = 1'b1;
      bus_b.req_addr  = 32'h0000_0000;
      #1;
      checkOutput("b2b_idle_ready", bus_b.req_ready, 1);
      step();
      checkOutput("b2b_w0_valid", bus_b.rsp_valid, 1);
      checkOutput("b2b_w0_data", bus_b.rsp_data, 32'h1111_0000);
      bus_b.req_addr = 32'h0000_0004;
      ld_en_b   = 1'b1;
      ld_addr_b = 8'd1;
      ld_data_b = 32'hDEAD_BEEF;
      #1;
      checkOutput("b2b_resp_ready", bus_b.req_ready, 1);
      step();
      ld_en_b = 1'b0;
      checkOutput("b2b_w1_valid", bus_b.rsp_valid, 1);
      checkOutput("rbw_old_word", bus_b.rsp_data, 32'h2222_0001);
      checkOutput("b2b_w1_count", fetch_count_b, 1);
      bus_b.req_addr = 32'h0000_0008;
      step();
      checkOutput("b2b_w2_valid", bus_b.rsp_valid, 1);
      checkOutput("b2b_w2_data", bus_b.rsp_data, 32'h3333_0002);
      checkOutput("b2b_w2_count", fetch_count_b, 2);
      bus_b.req_valid = 1'b0;
      step();
      checkOutput("b2b_end_valid", bus_b.rsp_valid, 0);
      checkOutput("b2b_end_count", fetch_count_b, 3);
      bus_b.req_valid = 1'b1;
      bus_b.req_addr  = 32'h0000_0004;
      step();
      bus_b.req_valid = 1'b0;
      checkOutput("rbw_new_word", bus_b.rsp_data, 32'hDEAD_BEEF);
      step();
      checkOutput("rbw_new_count", fetch_count_b, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

   // Bound on total run time in case the design stalls the sequence
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
